// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
// mux4_rr_arbiter_pkg : state/select encodings and rotate-priority helper
// Rev 1.0
// ============================================================================
`default_nettype none

package mux4_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_I0 = 2'd0;
  localparam logic [1:0] SEL_I1 = 2'd1;
  localparam logic [1:0] SEL_I2 = 2'd2;
  localparam logic [1:0] SEL_I3 = 2'd3;

  // First set request scanning last+1, last+2, ... (mod 4); last itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_arbiter_mux4_w.sv
// ============================================================================
// mux4_w : parameterised 4:1 mux, sel={S1,S0}: 00->I0 01->I1 10->I2 11->I3
// Rev 1.0
// ============================================================================
`default_nettype none

module mux4_w
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = i0;
    case (sel)
      SEL_I0:  y = i0;
      SEL_I1:  y = i1;
      SEL_I2:  y = i2;
      SEL_I3:  y = i3;
      default: y = i0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// mux4_rr_arbiter : round-robin arbiter sharing a 4:1 mux with valid/ready out
// Rev 1.0
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BEATS - 1);

  state_t     state;
  logic [1:0] last;
  logic [3:0] beat_cnt;
  logic [1:0] winner;
  logic       transfer;
  logic       rel;

  assign winner    = rr_pick(req, last);
  assign busy      = (state == ST_GRANT);
  assign out_valid = busy & req[sel];
  assign transfer  = out_valid & out_ready;
  // A dropped request ends the grant even though no beat was accepted.
  assign rel       = (transfer && (beat_cnt == LAST_BEAT)) || !req[sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= 4'b0000;
      sel      <= SEL_I0;
      last     <= SEL_I3;
      beat_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state    <= ST_GRANT;
            gnt      <= 4'b0001 << winner;
            sel      <= winner;
            last     <= winner;
            beat_cnt <= 4'd0;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            state    <= ST_IDLE;
            gnt      <= 4'b0000;
            beat_cnt <= 4'd0;
          end else if (transfer) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

  mux4_w #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .i0  (data0),
    .i1  (data1),
    .i2  (data2),
    .i3  (data3),
    .y   (out_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
// tb_mux4_rr_arbiter : table-driven plus directed sequences for mux4_rr_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] data0 = 8'h11, data1 = 8'h22, data2 = 8'h33, data3 = 8'h44;
  logic       out_ready = 1'b0;

  logic [3:0] gnt, gnt1;
  logic [1:0] sel, sel1;
  logic       out_valid, out_valid1;
  logic [7:0] out_data, out_data1;
  logic       busy, busy1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .out_ready(out_ready), .gnt(gnt), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  mux4_rr_arbiter #(.WIDTH(8), .MAX_BEATS(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .out_ready(out_ready), .gnt(gnt1), .sel(sel1),
    .out_valid(out_valid1), .out_data(out_data1), .busy(busy1)
  );

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       busy;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] dv[4];
    int         beats;
    int         g, ph;
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44;

    // Full-request rotation: 4 granted cycles then one bubble per requester, wrapping to 0.
    for (int i = 0; i < 21; i++) begin
      g  = i / 5;
      ph = i % 5;
      vecs[i].req = 4'b1111;
      vecs[i].rdy = 1'b1;
      vecs[i].sel = 2'(g);
      if (ph < 4) begin
        vecs[i].gnt   = 4'b0001 << (g % 4);
        vecs[i].valid = 1'b1;
        vecs[i].busy  = 1'b1;
        vecs[i].data  = dv[g % 4];
      end else begin
        vecs[i].gnt   = 4'b0000;
        vecs[i].valid = 1'b0;
        vecs[i].busy  = 1'b0;
        vecs[i].data  = dv[g % 4];
      end
    end

    // Reset state
    req = 4'b1111; out_ready = 1'b1;
    #2;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_sel", 32'(sel), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Rotation table with per-cycle mux data check
    for (int i = 0; i < 21; i++) begin
      req = vecs[i].req; out_ready = vecs[i].rdy;
      tick();
      check($sformatf("rot%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("rot%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
      check($sformatf("rot%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      check($sformatf("rot%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      if (vecs[i].busy)
        check($sformatf("rot%0d_data", i), 32'(out_data), 32'(vecs[i].data));
    end

    // Single requester 2, 1-cycle latency
    req = 4'b0000; out_ready = 1'b0;
    do_reset();
    data2 = 8'hA5;
    req = 4'b0100;
    tick();
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_sel", 32'(sel), 32'h2);
    check("t2_data", 32'(out_data), 32'hA5);
    check("t2_valid", 32'(out_valid), 32'h1);
    data2 = 8'h33;

    // Stalled consumer holds grant, then exactly 4 beats
    req = 4'b0000;
    do_reset();
    req = 4'b0001; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t3_hold%0d", i), 32'(gnt), 32'h1);
    end
    out_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 20 && gnt != 4'b0000; i++) begin
      if (out_valid && out_ready) beats++;
      tick();
    end
    check("t3_released", 32'(gnt), 32'h0);
    check("t3_beats", 32'(beats), 32'd4);

    // Requester 1 drops after 2 beats
    req = 4'b0000;
    do_reset();
    req = 4'b1110; out_ready = 1'b1;
    tick();
    check("t4_gnt1", 32'(gnt), 32'h2);
    tick();
    tick();
    check("t4_still", 32'(gnt), 32'h2);
    req = 4'b1100;
    #1;
    check("t4_valid_drop", 32'(out_valid), 32'h0);
    tick();
    check("t4_idle", 32'(gnt), 32'h0);
    tick();
    check("t4_next", 32'(gnt), 32'h4);
    check("t4_next_sel", 32'(sel), 32'h2);

    // Async reset mid-grant
    req = 4'b0000;
    do_reset();
    req = 4'b1000; out_ready = 1'b0;
    tick();
    check("t5_gnt3", 32'(gnt), 32'h8);
    req = 4'b1111;
    #1;
    rst = 1'b1;
    #1;
    check("t5_gnt_async", 32'(gnt), 32'h0);
    check("t5_busy_async", 32'(busy), 32'h0);
    check("t5_valid_async", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t5_after", 32'(gnt), 32'h1);

    // MAX_BEATS=1 instance: release after every accepted beat
    req = 4'b0000;
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    tick(); check("mb1_0", 32'(gnt1), 32'h1);
    tick(); check("mb1_1", 32'(gnt1), 32'h0);
    tick(); check("mb1_2", 32'(gnt1), 32'h2);
    tick(); check("mb1_3", 32'(gnt1), 32'h0);
    tick(); check("mb1_4", 32'(gnt1), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
